// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side constants and the fetch FSM state encoding.
package rv32i_pkg;

  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {instruction, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign count   = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with in-order response buffer and redirect drain.
// Define FETCH_MISALIGN_TRAP_EN to add the sticky misalign_trap output.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  localparam int          CW          = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIMIT = (CW+1)'(BUF_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, resp_pc_q, target;
  logic [CW-1:0]     out_q, out_d, disc_q, disc_d, fifo_count;
  logic [CW:0]       occupancy;
  logic              trap_q, trap_d, bad_target;
  logic              grant, resp, push, pop, fifo_empty;
  logic [2*XLEN-1:0] fifo_rdata;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = redirect_pc;
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign target     = redirect_pc & ~XLEN'(3);
  assign bad_target = 1'b0;
`endif

  assign occupancy = {1'b0, out_q} + {1'b0, fifo_count};
  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (out_q != '0);
  assign out_d     = out_q + CW'(grant) - CW'(resp);
  assign push      = resp && (state_q == RUN) && !redirect_valid;
  assign pop       = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      disc_q  <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
      trap_q  <= trap_d;
    end
  end

  // A redirect discards everything still in flight, counted after this cycle's traffic.
  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    trap_d  = trap_q;
    if (redirect_valid) begin
      disc_d  = out_d;
      trap_d  = bad_target;
      state_d = (out_d != '0) ? DRAIN : RUN;
    end else if (state_q == DRAIN) begin
      if (resp) disc_d = disc_q - CW'(1);
      if (disc_d == '0) state_d = RUN;
    end
  end

  always_comb begin
    imem_req   = !rst && (state_q == RUN) && !trap_q && !redirect_valid &&
                 (occupancy < DEPTH_LIMIT);
    imem_addr  = pc_q;
    inst_valid = !fifo_empty && !rst;
    inst_out   = fifo_rdata[2*XLEN-1:XLEN];
    inst_pc    = fifo_rdata[XLEN-1:0];
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_trap = trap_q && !rst;
`endif
  end

  // resp_pc_q tracks the address of the oldest outstanding request; the stream is contiguous.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
    end else begin
      out_q <= out_d;
      if (redirect_valid && !bad_target) begin
        pc_q      <= target;
        resp_pc_q <= target;
      end else begin
        if (grant) pc_q      <= pc_q + XLEN'(4);
        if (push)  resp_pc_q <= resp_pc_q + XLEN'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en   (push),
    .wr_data ({imem_rdata, resp_pc_q}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries, legal values 2 or 4.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports as follows, clock and reset first:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address; bits [1:0] always 00.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  new fetch target.
- inst_valid  out  1  instruction available to decode and immediate generation.
- inst_ready  in  1  decode consumes this cycle.
- inst_out  out  32  instruction word.
- inst_pc  out  32  address of inst_out.
- misalign_trap  out  1  present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-005 SHALL hold the fetch PC in a register that increments by 4 on each cycle with imem_req and imem_gnt both high; the increment wraps from FFFF_FFFC to 0000_0000.
REQ-006 SHALL drive imem_req high only while (outstanding requests + buffered entries) < BUF_DEPTH, state is RUN, and no redirect is presented this cycle.
REQ-007 SHALL hold imem_addr stable while imem_req is high and imem_gnt is low.
REQ-008 SHALL write each non-discarded response, paired with its request PC, into a FIFO; inst_valid rises the cycle after the write (one-cycle registered latency).
REQ-009 SHALL pop the FIFO on inst_valid and inst_ready; inst_out and inst_pc SHALL be stable while inst_valid is high and inst_ready is low.
REQ-010 SHALL use FSM states RUN and DRAIN:
- RUN -> DRAIN on redirect while requests are outstanding.
- DRAIN -> RUN when the discard counter reaches 0.
- RUN -> RUN on redirect with none outstanding.
REQ-011 On a redirect the block SHALL flush the FIFO, load the PC with redirect_pc, set the discard counter to the outstanding count (including any request granted that same cycle), and assert imem_req with redirect_pc no earlier than the next cycle in which the FSM is RUN.
REQ-012 In DRAIN the block SHALL drop each imem_rvalid and decrement the discard counter.
REQ-013 On simultaneous redirect and inst_ready handshake, the handshake completes and the flush takes priority for all remaining entries.
REQ-014 SHALL ignore imem_rvalid when the outstanding count is 0.
REQ-015 SHALL hold inst_valid low when the FIFO is empty and imem_req low when the buffer is full.

Reset
REQ-016 While rst is high, the block SHALL set:
- PC = RESET_PC.
- FIFO empty.
- Outstanding and discard counters = 0.
- FSM = RUN.
- inst_valid = 0, imem_req = 0, misalign_trap = 0.
REQ-017 SHALL assert imem_req with imem_addr = RESET_PC in the first cycle after rst falls.
REQ-018 Reset asserted mid-operation SHALL discard all state; responses still in flight are ignored per REQ-014.

Configuration
REQ-019 With FETCH_MISALIGN_TRAP_EN defined, a redirect with redirect_pc[1:0] != 00 SHALL:
- flush the block;
- not load the PC;
- stop fetching;
- set misalign_trap sticky high until the next aligned redirect or reset.
REQ-020 Without FETCH_MISALIGN_TRAP_EN, the misalign_trap port SHALL be absent and redirect_pc[1:0] SHALL be forced to 00.

Structure
REQ-021 Package rv32i_pkg SHALL hold XLEN = 32, the default RESET_PC constant, and the FSM state enumeration.
REQ-022 The FIFO SHALL be a sub-module named fetch_fifo, parameterised by depth and width (64: instruction plus PC).

Verification
REQ-023 Reset release, imem_gnt tied 1, one-cycle response -> request addresses 0, 4, 8, ...; first inst_valid with inst_pc = 0 three cycles after reset falls.
REQ-024 inst_ready held low -> exactly BUF_DEPTH requests issued, then imem_req = 0; inst_out stable until inst_ready rises.
REQ-025 Redirect to 0x100 with 2 requests outstanding -> both responses dropped; next inst_pc = 0x100.
REQ-026 PC = FFFF_FFFC -> next imem_addr = 0000_0000.
REQ-027 With the macro, redirect to 0x102 -> misalign_trap = 1 and imem_req = 0; then redirect to 0x200 -> trap clears and fetch resumes at 0x200.
REQ-028 rst pulsed while 2 requests are outstanding -> late imem_rvalid ignored; first inst_pc = RESET_PC.
